// File: rtl/rsa_msg_sequencer_if.sv
// Stream, key and engine signals of the RSA message sequencer.
// slave is the sequencer's view; master is the view of its environment.
interface rsa_msg_sequencer_if #(
  parameter int unsigned ARQ = 16
);
  localparam int unsigned DW = 2 * ARQ;

  logic          key_valid;
  logic          key_ready;
  logic [DW-1:0] key_exp;
  logic [DW-1:0] key_mod;
  logic          key_ok;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  logic          exp_load;
  logic [DW-1:0] exp_base;
  logic [DW-1:0] exp_exponent;
  logic [DW-1:0] exp_modulo;
  logic          exp_finish;
  logic [DW-1:0] exp_result;

  logic          busy;
  logic [15:0]   msg_count;
  logic [15:0]   err_count;

  modport slave (
    input  key_valid, key_exp, key_mod, in_valid, in_data, out_ready,
           exp_finish, exp_result,
    output key_ready, key_ok, in_ready, out_valid, out_data, out_err,
           exp_load, exp_base, exp_exponent, exp_modulo, busy,
           msg_count, err_count
  );

  modport master (
    output key_valid, key_exp, key_mod, in_valid, in_data, out_ready,
           exp_finish, exp_result,
    input  key_ready, key_ok, in_ready, out_valid, out_data, out_err,
           exp_load, exp_base, exp_exponent, exp_modulo, busy,
           msg_count, err_count
  );
endinterface

// File: rtl/rsa_msg_sequencer.sv
// Upstream controller for the modular-exponentiation engine: holds the key,
// range-checks each message, runs one engine job and returns the result.
module rsa_msg_sequencer #(
  parameter int unsigned ARQ     = 16,
  parameter int unsigned TIMEOUT = 72
) (
  input logic                clk,
  input logic                reset,
  rsa_msg_sequencer_if.slave bus
);
  localparam int unsigned DW = 2 * ARQ;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] key_exp_q, key_exp_d;
  logic [DW-1:0] key_mod_q, key_mod_d;
  logic          key_ok_q, key_ok_d;
  logic [DW-1:0] base_q, base_d;
  logic [DW-1:0] expo_q, expo_d;
  logic [DW-1:0] modu_q, modu_d;
  logic          load_q, load_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_err_q, out_err_d;
  logic [15:0]   msg_cnt_q, msg_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic          in_ready_c;

  // A key write in the same cycle blocks message acceptance.
  assign in_ready_c = (state_q == IDLE) && key_ok_q && !bus.key_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      key_exp_q   <= '0;
      key_mod_q   <= '0;
      key_ok_q    <= 1'b0;
      base_q      <= '0;
      expo_q      <= '0;
      modu_q      <= '0;
      load_q      <= 1'b0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      msg_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      key_exp_q   <= key_exp_d;
      key_mod_q   <= key_mod_d;
      key_ok_q    <= key_ok_d;
      base_q      <= base_d;
      expo_q      <= expo_d;
      modu_q      <= modu_d;
      load_q      <= load_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      msg_cnt_q   <= msg_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_exp_d   = key_exp_q;
    key_mod_d   = key_mod_q;
    key_ok_d    = key_ok_q;
    base_d      = base_q;
    expo_d      = expo_q;
    modu_d      = modu_q;
    load_d      = 1'b0;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    msg_cnt_d   = msg_cnt_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          key_exp_d = bus.key_exp;
          key_mod_d = bus.key_mod;
          key_ok_d  = (bus.key_mod > DW'(1));
        end else if (bus.in_valid && in_ready_c) begin
          if (bus.in_data >= key_mod_q) begin
            out_data_d  = '0;
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = OUT;
          end else begin
            base_d  = bus.in_data;
            expo_d  = key_exp_q;
            modu_d  = key_mod_q;
            load_d  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // First WAIT cycle (tmo_q==0) blanks a finish left over from the last job.
        if (bus.exp_finish && (tmo_q != '0)) begin
          out_data_d  = bus.exp_result;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          out_data_d  = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          msg_cnt_d   = msg_cnt_q + 16'd1;
          if (out_err_q) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.key_ready    = (state_q == IDLE);
  assign bus.key_ok       = key_ok_q;
  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_err      = out_err_q;
  assign bus.exp_load     = load_q;
  assign bus.exp_base     = base_q;
  assign bus.exp_exponent = expo_q;
  assign bus.exp_modulo   = modu_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.msg_count    = msg_cnt_q;
  assign bus.err_count    = err_cnt_q;
endmodule
